// File: rtl/nba_delay_sched.sv
// nba_delay_sched
// Schedules delayed register updates. Each accepted (value, delay) request
// sits in a slot and counts down. When its count expires the value is
// committed to out_value. If several slots expire on the same edge, the one
// accepted most recently wins.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   req_valid    request present
//   req_ready    at least one slot is free (combinational from slot state)
//   req_value    value to commit
//   req_delay    delay in cycles (0 behaves as 1)
//   out_value    last committed value (registered)
//   out_valid    sticky: some value has been committed since reset
//   out_update   one-cycle pulse on the cycle after a commit edge
//   pending_cnt  number of occupied slots
module nba_delay_sched #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int DELAY_W = 4,
    parameter int CNT_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_value,
    input  logic [DELAY_W-1:0] req_delay,
    output logic [WIDTH-1:0]   out_value,
    output logic               out_valid,
    output logic               out_update,
    output logic [CNT_W-1:0]   pending_cnt
);

    // Two slots that mature together were accepted fewer than 2^DELAY_W
    // accepts apart. One extra tag bit keeps the age comparison unambiguous
    // after the accept counter wraps.
    localparam int TAG_W = DELAY_W + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]   occ;
    logic [DELAY_W-1:0] cnt [DEPTH];
    logic [WIDTH-1:0]   val [DEPTH];
    logic [TAG_W-1:0]   tag [DEPTH];
    logic [TAG_W-1:0]   acc_seq;

    logic [DEPTH-1:0]   mature;
    logic [CNT_W-1:0]   n_mature;
    logic               commit;
    logic [WIDTH-1:0]   win_val;
    logic [TAG_W-1:0]   best_age;
    logic [TAG_W-1:0]   age;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               accept;
    logic [DELAY_W-1:0] eff_delay;

    assign req_ready = ~&occ;
    assign accept    = req_valid && req_ready;
    assign eff_delay = (req_delay == '0) ? DELAY_W'(1) : req_delay;

    always_comb begin
        mature     = '0;
        n_mature   = '0;
        commit     = 1'b0;
        win_val    = '0;
        best_age   = '1;
        age        = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && cnt[i] == DELAY_W'(1)) begin
                mature[i] = 1'b1;
                n_mature  = n_mature + CNT_W'(1);
                // Accepts since this slot was loaded; smallest = newest.
                age = acc_seq - tag[i];
                if (!commit || age < best_age) begin
                    commit   = 1'b1;
                    best_age = age;
                    win_val  = val[i];
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (!occ[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ         <= '0;
            acc_seq     <= '0;
            out_value   <= '0;
            out_valid   <= 1'b0;
            out_update  <= 1'b0;
            pending_cnt <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (occ[i]) begin
                    if (mature[i]) begin
                        occ[i] <= 1'b0;
                    end else begin
                        cnt[i] <= cnt[i] - DELAY_W'(1);
                    end
                end
            end
            // The chosen slot is empty, so it never collides with the
            // countdown updates above.
            if (accept) begin
                occ[free_idx] <= 1'b1;
                cnt[free_idx] <= eff_delay;
                val[free_idx] <= req_value;
                tag[free_idx] <= acc_seq;
                acc_seq       <= acc_seq + TAG_W'(1);
            end
            out_update <= commit;
            if (commit) begin
                out_value <= win_val;
                out_valid <= 1'b1;
            end
            pending_cnt <= pending_cnt + CNT_W'(accept) - n_mature;
        end
    end

endmodule

// File: tb/tb_nba_delay_sched.sv
// Directed bench for nba_delay_sched with a queue-based reference model of
// scheduled commits (absolute due edge, value, unbounded accept order).
module tb_nba_delay_sched;

    localparam int WIDTH   = 4;
    localparam int DEPTH   = 4;
    localparam int DELAY_W = 4;
    localparam int CNT_W   = 3;

    logic               clk;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic [WIDTH-1:0]   req_value;
    logic [DELAY_W-1:0] req_delay;
    logic [WIDTH-1:0]   out_value;
    logic               out_valid;
    logic               out_update;
    logic [CNT_W-1:0]   pending_cnt;

    nba_delay_sched #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .DELAY_W(DELAY_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_value(req_value),
        .req_delay(req_delay),
        .out_value(out_value),
        .out_valid(out_valid),
        .out_update(out_update),
        .pending_cnt(pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: list of scheduled commits keyed by absolute edge.
    typedef struct {
        int due;
        int val;
        int seq;
    } ev_t;

    ev_t q[$];
    int  ecount   = 0;
    int  seq_ctr  = 0;
    int  m_val    = 0;
    int  m_valid  = 0;
    int  m_upd    = 0;
    bit  chk_en   = 1'b0;
    int  best_seq;
    int  best_val;
    bit  m_ready;
    int  d_eff;

    initial begin
        forever begin
            @(posedge clk);
            ecount++;
            if (reset) begin
                q.delete();
                m_val   = 0;
                m_valid = 0;
                m_upd   = 0;
                chk_en  = 1'b1;
            end else begin
                m_ready  = (q.size() < DEPTH);
                best_seq = -1;
                best_val = 0;
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (q[i].due == ecount) begin
                        if (q[i].seq > best_seq) begin
                            best_seq = q[i].seq;
                            best_val = q[i].val;
                        end
                        q.delete(i);
                    end
                end
                m_upd = (best_seq >= 0) ? 1 : 0;
                if (best_seq >= 0) begin
                    m_val   = best_val;
                    m_valid = 1;
                end
                if (req_valid && m_ready) begin
                    d_eff = (req_delay == 0) ? 1 : int'(req_delay);
                    q.push_back('{ecount + d_eff, int'(req_value), seq_ctr});
                    seq_ctr++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_out_value",   32'(out_value),   m_val);
            chk("m_out_valid",   32'(out_valid),   m_valid);
            chk("m_out_update",  32'(out_update),  m_upd);
            chk("m_pending_cnt", 32'(pending_cnt), q.size());
            chk("m_req_ready",   32'(req_ready),   (q.size() < DEPTH) ? 1 : 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input int v, input int d);
        req_valid = 1'b1;
        req_value = WIDTH'(v);
        req_delay = DELAY_W'(d);
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_value = '0;
        req_delay = '0;
        step();
        step();
        reset = 1'b0;

        // Idle after reset.
        repeat (5) step();
        chk("idle_valid",   32'(out_valid),   0);
        chk("idle_value",   32'(out_value),   0);
        chk("idle_pending", 32'(pending_cnt), 0);
        chk("idle_ready",   32'(req_ready),   1);

        // Single request, delay 10: commits exactly 10 edges after accept.
        put(5, 10);
        for (int i = 0; i < 9; i++) begin
            step();
            chk("d10_early_valid", 32'(out_valid), 0);
        end
        step();
        chk("d10_value",  32'(out_value),  5);
        chk("d10_valid",  32'(out_valid),  1);
        chk("d10_update", 32'(out_update), 1);
        step();
        chk("d10_update_drop", 32'(out_update), 0);

        // Two requests maturing on the same edge: later accept wins.
        put(3, 4);
        put(9, 3);
        step();
        chk("tie_pre_update", 32'(out_update), 0);
        step();
        step();
        chk("tie_value",   32'(out_value),   9);
        chk("tie_update",  32'(out_update),  1);
        chk("tie_pending", 32'(pending_cnt), 0);
        step();
        chk("tie_update_drop", 32'(out_update), 0);

        // Fill all slots, then hold a fifth request until a slot frees.
        req_valid = 1'b1;
        req_delay = DELAY_W'(8);
        for (int i = 1; i <= 4; i++) begin
            req_value = WIDTH'(i);
            step();
        end
        chk("full_ready",   32'(req_ready),   0);
        chk("full_pending", 32'(pending_cnt), 4);
        req_value = WIDTH'(10);
        req_delay = DELAY_W'(2);
        repeat (4) step();
        chk("held_ready_low", 32'(req_ready), 0);
        step();
        chk("held_ready_high", 32'(req_ready),   1);
        chk("held_pending1",   32'(pending_cnt), 3);
        chk("held_value1",     32'(out_value),   1);
        step();
        req_valid = 1'b0;
        chk("held_pending2", 32'(pending_cnt), 3);
        chk("held_value2",   32'(out_value),   2);
        step();
        chk("held_value3",   32'(out_value),   3);
        chk("held_pending3", 32'(pending_cnt), 2);
        step();
        chk("held_wins",     32'(out_value),   10);
        chk("held_pending4", 32'(pending_cnt), 0);

        // Delay 0 behaves as delay 1; recommitting the same value still pulses.
        put(7, 0);
        chk("d0_no_commit_yet", 32'(out_update), 0);
        step();
        chk("d0_value",  32'(out_value),  7);
        chk("d0_update", 32'(out_update), 1);
        put(7, 1);
        step();
        chk("same_value",  32'(out_value),  7);
        chk("same_update", 32'(out_update), 1);
        step();

        // Reset while a request is in flight: it never commits.
        put(6, 6);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_valid",   32'(out_valid),   0);
        chk("rst_pending", 32'(pending_cnt), 0);
        chk("rst_value",   32'(out_value),   0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst_never_commits", 32'(out_value), 0);
        end

        // Dense mixed traffic, enough accepts to wrap the sequence tags.
        req_valid = 1'b1;
        for (int i = 0; i < 48; i++) begin
            req_value = WIDTH'(i % 16);
            req_delay = DELAY_W'((i * 5) % 7);
            step();
        end
        req_delay = DELAY_W'(15);
        req_value = WIDTH'(12);
        step();
        req_delay = DELAY_W'(1);
        for (int i = 0; i < 16; i++) begin
            req_value = WIDTH'(15 - i);
            step();
        end
        req_valid = 1'b0;
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nba_delay_sched.md
Name: nba_delay_sched

Overview:
- Cycle-based scheduler for delayed register updates: the clocked analogue of a nonblocking intra-assignment delay ("reg <= #d value").
- Accepts (value, delay) requests and holds each in a slot while it counts down.
- Commits the value to an output register when the delay expires.
- Feeds the downstream value register/checker stage that samples the output against expected values at fixed times.

Parameters:
- WIDTH, 4, bit width of scheduled values and of out_value.
- DEPTH, 4, number of in-flight request slots (2..16).
- DELAY_W, 4, bit width of req_delay.
- CNT_W, 3, width of pending_cnt; must hold DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  a slot is free this cycle; a request is accepted on an edge where req_valid && req_ready.
- req_value  input  WIDTH  value to commit.
- req_delay  input  DELAY_W  delay in clock cycles.
- out_value  output  WIDTH  committed value (registered).
- out_valid  output  1  high once any value has been committed since reset (sticky).
- out_update  output  1  one-cycle pulse on the cycle after a commit edge.
- pending_cnt  output  CNT_W  number of occupied slots.

Behaviour:
- Reset is synchronous and active-high.
  - On an edge with reset=1: out_value=0, out_valid=0, out_update=0, pending_cnt=0, all slots empty, sequence counter=0.
  - In-flight requests are discarded and never commit.
  - A request presented on a reset edge is ignored.
- req_ready is combinational from current slot state: 1 iff at least one slot is empty.
  - A slot that matures on edge k is not reusable on edge k; it becomes free at k+1.
- Acceptance at edge k:
  - The lowest-index empty slot loads the value.
  - Its countdown is loaded with max(req_delay,1); req_delay=0 behaves as 1.
  - Its sequence tag is loaded from a free-running accept counter, which increments per accept and wraps.
- Maturity:
  - Each occupied slot decrements once per edge.
  - A slot with count 1 at edge j commits at edge j and empties.
  - Net: a request accepted at edge k with effective delay d commits at edge k+d.
- Simultaneous maturity:
  - When several slots commit on the same edge, the slot accepted latest wins (last-scheduled-wins, matching NBA ordering).
  - Ordering uses the sequence tag compared relative to the accept counter, so it is correct across wrap.
  - All maturing slots empty.
- Commit edge:
  - out_value takes the winning value and out_valid becomes 1.
  - out_update=1 for the following cycle only.
  - Committing the same value as the current out_value still pulses out_update.
- Accept and commit on the same edge are independent.
  - pending_cnt updates to reflect both: +1 for an accept, −(number of maturing slots).
- Full: with pending_cnt=DEPTH, req_ready=0. A held req_valid is accepted on the first edge after a slot frees.
- Delay width: the maximum delay is 2^DELAY_W−1. There is no overflow; the countdown saturates at load only.
- Bursts: back-to-back accepts, one per edge, are supported with no bubbles while slots remain.

Test Plan:
1. Reset, then hold idle 5 cycles → out_valid=0, out_value=0, pending_cnt=0, req_ready=1.
2. Accept value=5, delay=10 at edge 3:
   - Edges 4..12 → out_valid=0.
   - Edge 13 → out_value=5, out_valid=1.
   - Cycle after edge 13 → out_update=1 for exactly one cycle.
3. Accept A=3/d=4 at edge 1 and B=9/d=3 at edge 2 (both mature at edge 5) → out_value=9 after edge 5, one out_update pulse, pending_cnt=0.
4. Issue DEPTH=4 requests with delay 8 on consecutive edges:
   - req_ready=0 with pending_cnt=4.
   - A 5th held request is accepted on the edge after the first slot matures.
5. Accept value=7 with delay 0 → commits on the next edge, same as delay 1.
6. Accept value=6/d=6, then assert reset 3 edges later → value 6 never appears, out_valid=0, pending_cnt=0.
